// File: rtl/isa_pkg.sv
// Isa: machine-wide sizes and the program loader state encoding.
// Shared by the loader RTL and by benches that probe its state.
package Isa;

   localparam int REGISTER_SIZE        = 16;
   localparam int MEMORY_ADDRESS_WIDTH = 8;

   typedef enum logic [2:0] {
      GET_ADDRESS,
      GET_COUNT,
      GET_HIGH,
      GET_LOW,
      WRITE,
      DONE
   } LoaderState;

endpackage

// File: rtl/program_loader.sv
// program_loader: turns a byte stream of {address, count, words...}
// blocks into RAM writes, holding the processor in reset until done.
// Ports:
//   i_clock, i_reset (async, active low)
//   i_byte_valid, i_byte, o_byte_ready  - load stream handshake
//   o_mem_write_enable, o_mem_address,
//   o_mem_write_data                    - single-port RAM write port
//   o_processor_reset (active low), o_done
module program_loader
   import Isa::*;
#(
   parameter int WORD_WIDTH    = REGISTER_SIZE,
   parameter int ADDRESS_WIDTH = MEMORY_ADDRESS_WIDTH
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_byte_valid,
   input  logic [7:0]               i_byte,
   output logic                     o_byte_ready,
   output logic                     o_mem_write_enable,
   output logic [ADDRESS_WIDTH-1:0] o_mem_address,
   output logic [WORD_WIDTH-1:0]    o_mem_write_data,
   output logic                     o_processor_reset,
   output logic                     o_done
);

   LoaderState state;
   LoaderState state_next;

   logic [ADDRESS_WIDTH-1:0] address_count;
   logic [7:0]               word_count;
   logic [7:0]               high_byte;
   logic [ADDRESS_WIDTH-1:0] mem_address;
   logic [WORD_WIDTH-1:0]    mem_data;
   logic                     accept;

   assign accept = i_byte_valid & o_byte_ready;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state <= GET_ADDRESS;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next         = state;
      o_byte_ready       = 1'b0;
      o_mem_write_enable = 1'b0;
      o_done             = 1'b0;
      o_processor_reset  = 1'b0;
      unique case (state)
         GET_ADDRESS: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) state_next = GET_COUNT;
         end
         GET_COUNT: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) begin
               state_next = (i_byte == 8'd0) ? DONE : GET_HIGH;
            end
         end
         GET_HIGH: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) state_next = GET_LOW;
         end
         GET_LOW: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) state_next = WRITE;
         end
         WRITE: begin
            o_mem_write_enable = 1'b1;
            // word_count still holds the pre-decrement value here
            state_next = (word_count == 8'd1) ? GET_ADDRESS : GET_HIGH;
         end
         DONE: begin
            o_done            = 1'b1;
            o_processor_reset = 1'b1;
         end
         default: state_next = GET_ADDRESS;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         address_count <= '0;
         word_count    <= '0;
         high_byte     <= '0;
         mem_address   <= '0;
         mem_data      <= '0;
      end else begin
         if (accept) begin
            unique case (state)
               GET_ADDRESS: address_count <= ADDRESS_WIDTH'(i_byte);
               GET_COUNT:   word_count    <= i_byte;
               GET_HIGH:    high_byte     <= i_byte;
               GET_LOW: begin
                  // output registers hold the word through WRITE and after
                  mem_address <= address_count;
                  mem_data    <= WORD_WIDTH'({high_byte, i_byte});
               end
               default: ;
            endcase
         end
         if (state == WRITE) begin
            address_count <= address_count + ADDRESS_WIDTH'(1);
            word_count    <= word_count - 8'd1;
         end
      end
   end

   assign o_mem_address    = mem_address;
   assign o_mem_write_data = mem_data;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed block streams into program_loader; a
// negedge monitor checks every RAM write against an expectation queue.
module tb_program_loader;
   import Isa::*;

   typedef struct {
      logic [7:0]  a;
      logic [15:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  b = 8'h00;
   logic        ready;
   logic        we;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        prst;
   logic        done;

   int          vectors = 0;
   int          miscompares = 0;
   int          writes = 0;
   int          w0;
   wr_t         exp_q[$];
   wr_t         e_mon;
   logic [15:0] ram[256];
   logic [15:0] blk[$];
   bit          ok;

   program_loader dut (
      .i_clock            (clk),
      .i_reset            (rst_n),
      .i_byte_valid       (valid),
      .i_byte             (b),
      .o_byte_ready       (ready),
      .o_mem_write_enable (we),
      .o_mem_address      (addr),
      .o_mem_write_data   (wdata),
      .o_processor_reset  (prst),
      .o_done             (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (we) begin
         writes++;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                     addr, wdata);
         end else begin
            e_mon = exp_q.pop_front();
            chk("write_addr", {24'd0, addr}, {24'd0, e_mon.a});
            chk("write_data", {16'd0, wdata}, {16'd0, e_mon.d});
         end
         ram[addr] = wdata;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_byte(input logic [7:0] v, input bit gaps);
      int n;
      if (gaps && $urandom_range(0, 1) == 1) begin
         valid = 1'b0;
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      valid = 1'b1;
      b = v;
      n = 0;
      forever begin
         ok = ready;
         @(posedge clk);
         #1;
         if (ok) break;
         n++;
         if (n > 50) begin
            chk("byte_accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      valid = 1'b0;
   endtask

   task automatic send_block(input logic [7:0] a, input bit gaps);
      wr_t e;
      for (int i = 0; i < blk.size(); i++) begin
         e.a = a + 8'(i);
         e.d = blk[i];
         exp_q.push_back(e);
      end
      send_byte(a, gaps);
      send_byte(8'(blk.size()), gaps);
      for (int i = 0; i < blk.size(); i++) begin
         send_byte(blk[i][15:8], gaps);
         send_byte(blk[i][7:0], gaps);
         chk("write_latency", {31'd0, we}, 32'd1);
      end
   endtask

   task automatic send_end(input bit gaps);
      send_byte(8'h00, gaps);
      send_byte(8'h00, gaps);
      chk("done", {31'd0, done}, 32'd1);
      chk("processor_reset_release", {31'd0, prst}, 32'd1);
      chk("ready_in_done", {31'd0, ready}, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'hDEAD;

      #12;
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_prst", {31'd0, prst}, 32'd0);
      chk("rst_addr", {24'd0, addr}, 32'd0);
      chk("rst_data", {16'd0, wdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);

      // two words from address 0, then terminator
      blk = '{16'h4165, 16'h0000};
      send_block(8'h00, 1'b0);
      send_end(1'b0);

      // bytes offered after DONE must not be consumed
      w0 = writes;
      valid = 1'b1;
      b = 8'hAB;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("done_ready", {31'd0, ready}, 32'd0);
         chk("done_hold", {31'd0, done}, 32'd1);
      end
      valid = 1'b0;
      chk("done_no_writes", writes, w0);

      do_reset();
      w0 = writes;
      blk = '{16'h0000, 16'h0001, 16'h0015, 16'hFFD6};
      send_block(8'h64, 1'b0);
      send_end(1'b0);
      chk("four_strobes", writes - w0, 32'd4);

      // address wrap from 255 to 0
      do_reset();
      blk = '{16'hAAAA, 16'h5555};
      send_block(8'hFF, 1'b0);
      send_end(1'b0);

      // same stream with random valid gaps
      do_reset();
      w0 = writes;
      blk = '{16'h0000, 16'h0001, 16'h0015, 16'hFFD6};
      send_block(8'h64, 1'b1);
      send_end(1'b1);
      chk("gap_four_strobes", writes - w0, 32'd4);

      // reset after the high byte of the second word
      do_reset();
      exp_q.push_back('{a: 8'h10, d: 16'h1234});
      send_byte(8'h10, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      w0 = writes;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_state", {29'd0, dut.state}, {29'd0, GET_ADDRESS});
      chk("abort_we", {31'd0, we}, 32'd0);
      chk("abort_prst", {31'd0, prst}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_write", writes, w0);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_prst_after", {31'd0, prst}, 32'd0);

      chk("ram_0", {16'd0, ram[0]}, 32'h5555);
      chk("ram_1", {16'd0, ram[1]}, 32'h0000);
      chk("ram_100", {16'd0, ram[100]}, 32'h0000);
      chk("ram_101", {16'd0, ram[101]}, 32'h0001);
      chk("ram_102", {16'd0, ram[102]}, 32'h0015);
      chk("ram_103", {16'd0, ram[103]}, 32'hFFD6);
      chk("ram_255", {16'd0, ram[255]}, 32'hAAAA);
      chk("ram_16", {16'd0, ram[16]}, 32'h1234);
      chk("ram_17", {16'd0, ram[17]}, 32'hDEAD);
      chk("pending_writes", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default Isa::REGISTER_SIZE (16), width of one memory word.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default Isa::MEMORY_ADDRESS_WIDTH (8), memory address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to the clock.
REQ-004 i_clock  input  1  system clock, all state updates on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_byte_valid  input  1  load byte present on i_byte.
REQ-007 i_byte  input  8  load stream byte.
REQ-008 o_byte_ready  output  1  loader accepts i_byte this cycle.
REQ-009 o_mem_write_enable  output  1  one-cycle write strobe to the single-port RAM.
REQ-010 o_mem_address  output  ADDRESS_WIDTH  RAM write address.
REQ-011 o_mem_write_data  output  WORD_WIDTH  RAM write data.
REQ-012 o_processor_reset  output  1  active-low reset to the downstream processor; low while loading.
REQ-013 o_done  output  1  high once the terminating block has been accepted.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where i_byte_valid and o_byte_ready are both high.
REQ-015 Stream format SHALL be repeated blocks: address byte, count byte N, then N words, each sent high byte first.
REQ-016 States SHALL be GET_ADDRESS, GET_COUNT, GET_HIGH, GET_LOW, WRITE, DONE.
REQ-017 GET_ADDRESS: accepted byte loads the address counter; next state GET_COUNT.
REQ-018 GET_COUNT: accepted N = 0 SHALL go to DONE; N > 0 loads the word counter with N and goes to GET_HIGH.
REQ-019 GET_HIGH: accepted byte is stored as data[15:8]; next state GET_LOW.
REQ-020 GET_LOW: accepted byte is stored as data[7:0]; next state WRITE.
REQ-021 WRITE: o_mem_write_enable SHALL be high for exactly this one cycle, with o_mem_address = address counter and o_mem_write_data = assembled word.
REQ-022 Leaving WRITE, the address counter SHALL increment modulo 2^ADDRESS_WIDTH (255 wraps to 0) and the word counter SHALL decrement.
REQ-023 Leaving WRITE, the next state SHALL be GET_ADDRESS if the word counter reaches 0, else GET_HIGH.
REQ-024 o_byte_ready SHALL be high in GET_* states and low in WRITE and DONE; bytes offered in WRITE/DONE are not consumed.
REQ-025 Latency SHALL be 1 cycle from acceptance of the low byte to the write strobe; sustained throughput is one word per 3 cycles.
REQ-026 DONE SHALL be terminal until reset, with o_done = 1 and o_processor_reset = 1; in all other states both are 0.
REQ-027 o_mem_write_enable SHALL be 0 outside WRITE; address and data outputs hold their last values.
REQ-028 Idle i_byte_valid (low) in any GET_* state SHALL stall that state without side effects.

Reset
REQ-029 Asserting i_reset low SHALL immediately, regardless of clock, force GET_ADDRESS, counters and data to 0, o_mem_write_enable 0, o_done 0, o_processor_reset 0.
REQ-030 Reset mid-block or during WRITE SHALL abort without a write; the partially received block is discarded and earlier RAM writes are kept.
REQ-031 Reset deassertion SHALL take effect on the next rising edge; no byte is accepted on that edge unless the state is GET_ADDRESS with i_byte_valid high.

Structure
REQ-032 Word and address widths SHALL come from the Isa package; the loader state enum SHALL be declared in the Isa package as LoaderState so benches can probe it.
REQ-033 No sub-module is required; the block is one FSM with a byte assembler and two counters.

Verification
REQ-034 Block {0x00, 0x02, 0x41, 0x65, 0x00, 0x00} then {0x00, 0x00} -> mem[0] = 0x4165, mem[1] = 0x0000, then o_done = 1 and o_processor_reset = 1.
REQ-035 Block {0x64, 0x04, words 0x0000, 0x0001, 0x0015, 0xFFD6} -> mem[100..103] = 0, 1, 21, -42; exactly 4 write strobes.
REQ-036 Block at 0xFF with N = 2, words 0xAAAA, 0x5555 -> mem[255] = 0xAAAA, mem[0] = 0x5555 (address wraps).
REQ-037 Random i_byte_valid gaps (50%) over the REQ-035 stream -> identical RAM contents; no byte is consumed while o_byte_ready = 0.
REQ-038 Reset pulsed low after only the high byte of the second word -> no write for that word, state GET_ADDRESS, o_processor_reset = 0; first word remains in RAM.
REQ-039 Bytes offered after DONE -> o_byte_ready stays 0, no writes, and o_done remains 1.
